alu_pipe: RTL and testbench
===========================

Name: alu_pipe

Overview:
Parametrised, handshaked successor to the 4-bit combinational ALU. It provides a WIDTH-bit datapath built from 4-bit carry-lookahead slices, with a registered result and flags. Adds SLTU and an iterative shift-and-add multiply. It sits between the operand-issue logic and the writeback stage, using valid/ready on both sides.

Parameters:
WIDTH, 8, datapath width; must be a multiple of 4 and at least 4.
OPW, 4, opcode width; fixed at 4 and exposed only for package consistency.

Ports:
clk  input  1  clock; all state updates on the rising edge.
rst_n  input  1  asynchronous active-low reset.
in_valid  input  1  operand/opcode presented.
in_ready  output  1  block can accept this cycle.
a  input  WIDTH  operand A (two's complement for signed ops).
b  input  WIDTH  operand B.
op  input  OPW  opcode, encoded as below.
out_valid  output  1  result/flags valid.
out_ready  input  1  consumer accepts result.
result  output  WIDTH  registered result.
carry  output  1  registered carry flag.
overflow  output  1  registered signed-overflow flag.
zero  output  1  registered flag; 1 when result == 0.
err  output  1  registered flag; 1 for a reserved opcode.

Behaviour:
- Opcodes. op[2] is binvert and op[1:0] selects the function.
  - 0000 AND, 0001 OR, 0010 ADD.
  - 0100 a&~b, 0101 a|~b, 0110 SUB (a+~b+1).
  - 0111 SLT (signed), 1111 SLTU (unsigned).
  - 1000 MUL (low WIDTH bits of the unsigned product).
  - All other opcodes are reserved.
- Adder. Carry-in is op[2]. carry is the MSB carry-out. overflow is the carry into the MSB XOR the carry out of the MSB.
- SLT. result = {0…, sum[MSB]^ovf}. SLTU: result = {0…, ~carry}. For both, carry=0 and overflow=0.
- Logic ops: carry=0, overflow=0.
- MUL: carry=1 iff the upper WIDTH bits of the full product are nonzero; overflow=0.
- Reserved opcodes: result=0, carry=0, overflow=0, zero=1, err=1. Latency is 1.
- Reset state: state=IDLE, out_valid=0, result=0, carry=0, overflow=0, zero=0, err=0, in_ready=1. The multiply counter and operands are cleared.
- FSM states: IDLE, MUL, HOLD.
  - IDLE: in_ready=1. Accept on in_valid&&in_ready.
    - Single-cycle op accepted at edge N: result and flags registered at edge N, out_valid=1 → HOLD.
    - MUL accepted at edge N: latch a, b, clear the accumulator, count=WIDTH-1 → MUL.
  - MUL: in_ready=0. One shift-add step per cycle (add a<<i when b[i]=1).
    - The final step, at count==0, writes result/flags at edge N+WIDTH; out_valid=1 → HOLD.
  - HOLD: out_valid=1, result/flags held stable.
    - in_ready = out_ready. Accept and output handshake may occur in the same cycle, giving back-to-back single-cycle ops at 1 per clock.
    - Handshake with no new accept → IDLE with out_valid=0.
    - Handshake with a new accept: behaves as in IDLE, but out_valid stays 1 for a single-cycle op; a MUL drops out_valid and goes to MUL.
- in_valid while in_ready=0 is ignored; no queueing.
- Operands are sampled only at accept. Changes to a, b or op during MUL have no effect.
- Reset asserted mid-MUL or in HOLD returns immediately to the reset state; the pending result is discarded.
- Width wrap: ADD/SUB/MUL results are truncated to WIDTH bits; carry reports the lost information.

Decomposition:
- Package alu_pipe_pkg holds the opcode localparams (OP_AND…OP_MUL), FSM state encoding, and a function is_reserved(op).
- Sub-module alu_cla_slice: 4-bit slice with inputs a, b, cin, binvert, select and outputs sum/logic result, G, P and MSB-carry-in. alu_pipe instantiates WIDTH/4 slices plus a lookahead carry unit.

Test Plan (WIDTH=8):
- ADD a=0x7F b=0x01 accepted at edge N → out_valid at N; result=0x80, overflow=1, carry=0, zero=0.
- SUB a=0x80 b=0x01 → result=0x7F, overflow=1, carry=1. SUB a=0xF9 b=0xF9 → result=0x00, zero=1, carry=1.
- SLT a=0xF9 b=0xFF → 0x01. SLT a=0xFF b=0x01 → 0x01 while SLTU a=0xFF b=0x01 → 0x00. SLTU a=0x01 b=0xFF → 0x01.
- MUL a=0x0F b=0x11 accepted at N → in_ready=0 for 8 cycles, out_valid at N+8, result=0xFF, carry=0. MUL a=0x10 b=0x10 → result=0x00, carry=1, zero=1.
- Backpressure and streaming:
  - Hold out_ready=0 for 3 cycles after an ADD → result/flags stable and in_ready=0.
  - Then stream 4 ADDs with in_valid=out_ready=1 → one result per clock, in order.
  - Opcode 0011 → err=1, result=0.
- Assert rst_n low 3 cycles into a MUL → out_valid=0 and in_ready=1 immediately. After release, the next ADD 0x02+0x03 → 0x05 with normal latency.

Source files
------------

// File: rtl/alu_pipe_pkg.sv
// -----------------------------------------------------------------------------
// alu_pipe_pkg
// Shared definitions for the pipelined ALU: opcode encodings, the control FSM
// state encoding and the reserved-opcode decoder.
// Opcode layout: op[2] inverts operand B (and is the adder carry-in),
// op[1:0] selects AND / OR / SUM / SLT; op[3] marks MUL and SLTU.
// -----------------------------------------------------------------------------
package alu_pipe_pkg;

    localparam int OP_W = 4;

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_ANDN = 4'b0100;
    localparam logic [3:0] OP_ORN  = 4'b0101;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_SLT  = 4'b0111;
    localparam logic [3:0] OP_SLTU = 4'b1111;
    localparam logic [3:0] OP_MUL  = 4'b1000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_MUL  = 2'b01,
        ST_HOLD = 2'b10
    } state_t;

    // Any encoding outside the nine defined operations is reserved.
    function automatic logic is_reserved(input logic [3:0] op);
        logic res_v;
        case (op)
            OP_AND, OP_OR, OP_ADD, OP_ANDN, OP_ORN,
            OP_SUB, OP_SLT, OP_SLTU, OP_MUL: res_v = 1'b0;
            default:                         res_v = 1'b1;
        endcase
        return res_v;
    endfunction

endpackage

// File: rtl/alu_cla_slice.sv
// -----------------------------------------------------------------------------
// alu_cla_slice
// 4-bit ALU slice with internal carry lookahead.
// Ports:
//   a, b     : 4-bit operand slices
//   cin      : carry into bit 0 of this slice (from the group lookahead unit)
//   binvert  : invert b before use
//   select   : 00 AND, 01 OR, 1x SUM
//   res      : selected 4-bit result
//   g, p     : group generate / propagate for the upper lookahead level
//   msb_cin  : carry into bit 3 (used for signed overflow on the top slice)
// -----------------------------------------------------------------------------
module alu_cla_slice
    import alu_pipe_pkg::*;
(
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    input  logic       binvert,
    input  logic [1:0] select,
    output logic [3:0] res,
    output logic       g,
    output logic       p,
    output logic       msb_cin
);

    logic [3:0] bb_s;
    logic [3:0] gen_s;
    logic [3:0] prop_s;
    logic [3:0] c_s;
    logic [3:0] sum_s;

    // Bit-level generate/propagate, lookahead carries and result select.
    always_comb begin
        bb_s   = binvert ? ~b : b;
        gen_s  = a & bb_s;
        prop_s = a ^ bb_s;

        c_s[0] = cin;
        c_s[1] = gen_s[0] | (prop_s[0] & cin);
        c_s[2] = gen_s[1] | (prop_s[1] & gen_s[0]) | (prop_s[1] & prop_s[0] & cin);
        c_s[3] = gen_s[2] | (prop_s[2] & gen_s[1]) | (prop_s[2] & prop_s[1] & gen_s[0])
               | (prop_s[2] & prop_s[1] & prop_s[0] & cin);

        sum_s = prop_s ^ c_s;

        g = gen_s[3] | (prop_s[3] & gen_s[2]) | (prop_s[3] & prop_s[2] & gen_s[1])
          | (prop_s[3] & prop_s[2] & prop_s[1] & gen_s[0]);
        p = &prop_s;
        msb_cin = c_s[3];

        case (select)
            2'b00:   res = a & bb_s;
            2'b01:   res = a | bb_s;
            2'b10:   res = sum_s;
            2'b11:   res = sum_s;
            default: res = sum_s;
        endcase
    end

endmodule

// File: rtl/alu_pipe.sv
// -----------------------------------------------------------------------------
// alu_pipe
// Handshaked WIDTH-bit ALU with registered result/flags and an iterative
// shift-and-add multiplier.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid / in_ready : operand handshake (a, b, op sampled on accept)
//   out_valid/out_ready : result handshake
//   result              : registered WIDTH-bit result
//   carry, overflow     : registered adder / multiply flags
//   zero, err           : registered result==0 and reserved-opcode flags
// Single-cycle ops register their result on the accepting edge; MUL takes
// WIDTH further edges. In HOLD a new accept may coincide with the output
// handshake, so single-cycle ops stream at one per clock.
// -----------------------------------------------------------------------------
module alu_pipe
    import alu_pipe_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int OPW   = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [OPW-1:0]   op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             overflow,
    output logic             zero,
    output logic             err
);

    localparam int NS = WIDTH / 4;
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_ZERO = CW'(0);

    // Carry into slice k from the group generate/propagate of slices below it.
    function automatic logic lookahead(input logic [NS-1:0] g, input logic [NS-1:0] p,
                                       input logic c0, input int k);
        logic c_v;
        logic t_v;
        c_v = c0;
        for (int i = 0; i < k; i++) begin
            c_v = c_v & p[i];
        end
        for (int j = 0; j < k; j++) begin
            t_v = g[j];
            for (int m = j + 1; m < k; m++) begin
                t_v = t_v & p[m];
            end
            c_v = c_v | t_v;
        end
        return c_v;
    endfunction

    state_t                 state_r;
    logic                   out_valid_r;
    logic [WIDTH-1:0]       result_r;
    logic                   carry_r;
    logic                   overflow_r;
    logic                   zero_r;
    logic                   err_r;
    logic [CW-1:0]          count_r;
    logic [2*WIDTH-1:0]     acc_r;
    logic [2*WIDTH-1:0]     mcand_r;
    logic [WIDTH-1:0]       mplier_r;

    logic [WIDTH-1:0]       slice_res_s;
    logic [NS-1:0]          grp_g_s;
    logic [NS-1:0]          grp_p_s;
    logic [NS:0]            grp_c_s;
    // Every slice reports its bit-3 carry-in; only the top slice's entry is read.
    logic [NS-1:0]          msb_cin_unused_s;
    logic                   add_cout_s;
    logic                   add_ovf_s;
    logic [WIDTH-1:0]       alu_res_s;
    logic                   alu_carry_s;
    logic                   alu_ovf_s;
    logic [2*WIDTH-1:0]     acc_next_s;
    logic                   in_ready_s;
    logic                   accept_s;
    logic                   handshake_s;

    genvar k;
    generate
        for (k = 0; k < NS; k++) begin : g_slice
            alu_cla_slice u_slice (
                .a       (a[4*k +: 4]),
                .b       (b[4*k +: 4]),
                .cin     (grp_c_s[k]),
                .binvert (op[2]),
                .select  (op[1:0]),
                .res     (slice_res_s[4*k +: 4]),
                .g       (grp_g_s[k]),
                .p       (grp_p_s[k]),
                .msb_cin (msb_cin_unused_s[k])
            );
        end
    endgenerate

    // Second-level lookahead carry unit across slices; carry-in is binvert.
    always_comb begin
        grp_c_s    = {(NS+1){1'b0}};
        grp_c_s[0] = op[2];
        for (int i = 1; i <= NS; i++) begin
            grp_c_s[i] = lookahead(grp_g_s, grp_p_s, op[2], i);
        end
    end

    // Single-cycle result and flags decoded from the slice outputs.
    always_comb begin
        add_cout_s  = grp_c_s[NS];
        add_ovf_s   = msb_cin_unused_s[NS-1] ^ grp_c_s[NS];
        alu_res_s   = {WIDTH{1'b0}};
        alu_carry_s = 1'b0;
        alu_ovf_s   = 1'b0;
        case (op)
            OP_AND, OP_OR, OP_ANDN, OP_ORN: begin
                alu_res_s = slice_res_s;
            end
            OP_ADD, OP_SUB: begin
                alu_res_s   = slice_res_s;
                alu_carry_s = add_cout_s;
                alu_ovf_s   = add_ovf_s;
            end
            OP_SLT: begin
                alu_res_s = {{(WIDTH-1){1'b0}}, slice_res_s[WIDTH-1] ^ add_ovf_s};
            end
            OP_SLTU: begin
                // a - b borrows (no carry out) exactly when a < b unsigned.
                alu_res_s = {{(WIDTH-1){1'b0}}, ~add_cout_s};
            end
            default: begin
                alu_res_s = {WIDTH{1'b0}};
            end
        endcase
    end

    // One shift-and-add step: add the shifted multiplicand when the current multiplier bit is set.
    always_comb begin
        if (mplier_r[0]) begin
            acc_next_s = acc_r + mcand_r;
        end else begin
            acc_next_s = acc_r;
        end
    end

    // Input readiness: free in IDLE, tied to the consumer in HOLD, busy during MUL.
    always_comb begin
        case (state_r)
            ST_IDLE: in_ready_s = 1'b1;
            ST_HOLD: in_ready_s = out_ready;
            ST_MUL:  in_ready_s = 1'b0;
            default: in_ready_s = 1'b0;
        endcase
        accept_s    = in_valid & in_ready_s;
        handshake_s = out_valid_r & out_ready;
    end

    // Control FSM with registered result, flags and multiplier state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            out_valid_r <= 1'b0;
            result_r    <= {WIDTH{1'b0}};
            carry_r     <= 1'b0;
            overflow_r  <= 1'b0;
            zero_r      <= 1'b0;
            err_r       <= 1'b0;
            count_r     <= CNT_ZERO;
            acc_r       <= {(2*WIDTH){1'b0}};
            mcand_r     <= {(2*WIDTH){1'b0}};
            mplier_r    <= {WIDTH{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE, ST_HOLD: begin
                    // In HOLD an accept implies out_ready, so the old result is consumed too.
                    if (accept_s) begin
                        if (op == OP_MUL) begin
                            state_r     <= ST_MUL;
                            out_valid_r <= 1'b0;
                            acc_r       <= {(2*WIDTH){1'b0}};
                            mcand_r     <= {{WIDTH{1'b0}}, a};
                            mplier_r    <= b;
                            count_r     <= CNT_LAST;
                        end else begin
                            state_r     <= ST_HOLD;
                            out_valid_r <= 1'b1;
                            result_r    <= alu_res_s;
                            carry_r     <= alu_carry_s;
                            overflow_r  <= alu_ovf_s;
                            zero_r      <= (alu_res_s == {WIDTH{1'b0}});
                            err_r       <= is_reserved(op);
                        end
                    end else if (handshake_s) begin
                        state_r     <= ST_IDLE;
                        out_valid_r <= 1'b0;
                    end
                end
                ST_MUL: begin
                    acc_r    <= acc_next_s;
                    mcand_r  <= mcand_r << 1;
                    mplier_r <= mplier_r >> 1;
                    if (count_r == CNT_ZERO) begin
                        state_r     <= ST_HOLD;
                        out_valid_r <= 1'b1;
                        result_r    <= acc_next_s[WIDTH-1:0];
                        carry_r     <= |acc_next_s[2*WIDTH-1:WIDTH];
                        overflow_r  <= 1'b0;
                        zero_r      <= (acc_next_s[WIDTH-1:0] == {WIDTH{1'b0}});
                        err_r       <= 1'b0;
                    end else begin
                        count_r <= count_r - CNT_ONE;
                    end
                end
                default: begin
                    state_r     <= ST_IDLE;
                    out_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_s;
    assign out_valid = out_valid_r;
    assign result    = result_r;
    assign carry     = carry_r;
    assign overflow  = overflow_r;
    assign zero      = zero_r;
    assign err       = err_r;

endmodule

// File: tb/tb_alu_pipe.sv
// -----------------------------------------------------------------------------
// tb_alu_pipe
// Self-checking bench for alu_pipe (WIDTH=8): directed vectors, backpressure,
// streaming, reset during MUL and randomized operations, all compared against
// an arithmetic reference model.
// -----------------------------------------------------------------------------
module tb_alu_pipe;

    localparam int W    = 8;
    localparam int MAXU = (1 << W) - 1;

    localparam logic [3:0] T_AND  = 4'b0000;
    localparam logic [3:0] T_OR   = 4'b0001;
    localparam logic [3:0] T_ADD  = 4'b0010;
    localparam logic [3:0] T_ANDN = 4'b0100;
    localparam logic [3:0] T_ORN  = 4'b0101;
    localparam logic [3:0] T_SUB  = 4'b0110;
    localparam logic [3:0] T_SLT  = 4'b0111;
    localparam logic [3:0] T_SLTU = 4'b1111;
    localparam logic [3:0] T_MUL  = 4'b1000;

    typedef struct packed {
        logic [W-1:0] res;
        logic         c;
        logic         v;
        logic         z;
        logic         e;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [3:0]   op;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic         carry;
    logic         overflow;
    logic         zero;
    logic         err;

    int total = 0;
    int bad   = 0;

    alu_pipe #(.WIDTH(W), .OPW(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .op        (op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .carry     (carry),
        .overflow  (overflow),
        .zero      (zero),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: plain integer arithmetic on the operand values.
    function automatic exp_t model(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        exp_t        e;
        int unsigned ua;
        int unsigned ub;
        int unsigned full;
        int          sa;
        int          sb;
        int          sf;
        e  = '0;
        ua = x;
        ub = y;
        sa = $signed(x);
        sb = $signed(y);
        case (o)
            T_AND:  e.res = x & y;
            T_OR:   e.res = x | y;
            T_ANDN: e.res = x & ~y;
            T_ORN:  e.res = x | ~y;
            T_ADD: begin
                full  = ua + ub;
                e.res = W'(full);
                e.c   = (full > MAXU);
                sf    = sa + sb;
                e.v   = (sf > 127) || (sf < -128);
            end
            T_SUB: begin
                full  = ua + (MAXU - ub) + 1;
                e.res = W'(full);
                e.c   = (full > MAXU);
                sf    = sa - sb;
                e.v   = (sf > 127) || (sf < -128);
            end
            T_SLT:  e.res = (sa < sb) ? 8'd1 : 8'd0;
            T_SLTU: e.res = (ua < ub) ? 8'd1 : 8'd0;
            T_MUL: begin
                full  = ua * ub;
                e.res = W'(full);
                e.c   = (full > MAXU);
            end
            default: e.e = 1'b1;
        endcase
        e.z = (e.res == 0);
        return e;
    endfunction

    task automatic check_out(input string tag, input exp_t e);
        check_eq({tag, ".res"}, 32'(result), 32'(e.res));
        check_eq({tag, ".c"}, 32'(carry), 32'(e.c));
        check_eq({tag, ".v"}, 32'(overflow), 32'(e.v));
        check_eq({tag, ".z"}, 32'(zero), 32'(e.z));
        check_eq({tag, ".e"}, 32'(err), 32'(e.e));
    endtask

    // One transaction from idle: accept, wait (bounded), check, drain.
    task automatic do_op(input string tag, input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        exp_t e;
        int   lat;
        int   ready_hi;
        e         = model(o, x, y);
        out_ready = 1'b1;
        op        = o;
        a         = x;
        b         = y;
        in_valid  = 1'b1;
        tick();
        in_valid  = 1'b0;
        a         = W'($urandom);
        b         = W'($urandom);
        op        = 4'($urandom);
        lat       = 0;
        ready_hi  = 0;
        while (!out_valid && lat < 40) begin
            if (in_ready) ready_hi++;
            tick();
            lat++;
        end
        check_eq({tag, ".lat"}, 32'(lat), (o == T_MUL) ? 32'(W) : 32'd0);
        if (o == T_MUL) check_eq({tag, ".busy"}, 32'(ready_hi), 32'd0);
        check_out(tag, e);
        tick();
        check_eq({tag, ".drain"}, 32'(out_valid), 32'd0);
    endtask

    logic [3:0]   d_op [14] = '{T_ADD, T_SUB, T_SUB, T_SLT, T_SLT, T_SLTU, T_SLTU,
                                T_MUL, T_MUL, 4'b0011, T_AND, T_OR, T_ANDN, T_ORN};
    logic [W-1:0] d_a  [14] = '{8'h7F, 8'h80, 8'hF9, 8'hF9, 8'hFF, 8'hFF, 8'h01,
                                8'h0F, 8'h10, 8'h5A, 8'hF0, 8'hF0, 8'hF0, 8'hF0};
    logic [W-1:0] d_b  [14] = '{8'h01, 8'h01, 8'hF9, 8'hFF, 8'h01, 8'h01, 8'hFF,
                                8'h11, 8'h10, 8'hA5, 8'h3C, 8'h3C, 8'h3C, 8'h3C};
    logic [3:0]   legal [9] = '{T_AND, T_OR, T_ADD, T_ANDN, T_ORN, T_SUB, T_SLT, T_SLTU, T_MUL};
    logic [W-1:0] s_a  [4]  = '{8'h01, 8'h7F, 8'hFF, 8'h40};
    logic [W-1:0] s_b  [4]  = '{8'h02, 8'h7F, 8'h01, 8'hC0};

    initial begin
        exp_t       e0;
        logic [3:0] ro;
        int         pick;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        op        = '0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst.valid", 32'(out_valid), 32'd0);
        check_eq("rst.ready", 32'(in_ready), 32'd1);
        check_out("rst", '0);
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 14; i++) begin
            do_op($sformatf("dir%0d", i), d_op[i], d_a[i], d_b[i]);
        end

        // Backpressure: result held while out_ready is low; extra in_valid ignored.
        e0        = model(T_ADD, 8'h12, 8'h34);
        out_ready = 1'b0;
        op        = T_ADD;
        a         = 8'h12;
        b         = 8'h34;
        in_valid  = 1'b1;
        tick();
        check_eq("bp.valid0", 32'(out_valid), 32'd1);
        check_out("bp0", e0);
        a = 8'hFF;
        b = 8'hFF;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_eq("bp.ready", 32'(in_ready), 32'd0);
            check_eq("bp.valid", 32'(out_valid), 32'd1);
            check_out("bp.hold", e0);
        end

        // Streaming: one result per clock, in order.
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            a        = s_a[i];
            b        = s_b[i];
            op       = T_ADD;
            in_valid = 1'b1;
            tick();
            check_eq("stream.valid", 32'(out_valid), 32'd1);
            check_out($sformatf("stream%0d", i), model(T_ADD, s_a[i], s_b[i]));
        end
        in_valid = 1'b0;
        tick();
        check_eq("stream.end", 32'(out_valid), 32'd0);

        // Reset three cycles into a MUL discards it immediately.
        op       = T_MUL;
        a        = 8'h0F;
        b        = 8'h11;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (3) tick();
        rst_n = 1'b0;
        #1;
        check_eq("mrst.valid", 32'(out_valid), 32'd0);
        check_eq("mrst.ready", 32'(in_ready), 32'd1);
        check_eq("mrst.res", 32'(result), 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        do_op("post_rst", T_ADD, 8'h02, 8'h03);

        for (int i = 0; i < 80; i++) begin
            pick = $urandom_range(0, 9);
            if (pick == 9) ro = 4'($urandom_range(0, 15));
            else ro = legal[pick];
            do_op($sformatf("rnd%0d", i), ro, W'($urandom), W'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
